ahb_apb_bridge_param: RTL

Parametrised AHB-Lite to APB bridge. It replaces the fixed 3-slave, 32-bit bridge, which had no wait states and no error reporting. It adds:
- configurable address/data width and slave count,
- APB wait states via per-slave `pready`,
- error propagation via `pslverr`,
- out-of-range decode errors,
- an optional APB timeout.

It sits between the AHB interconnect (as a single AHB slave) and the APB peripheral bus.

---
 rtl/ahb_apb_pkg.sv | 36 +++
 rtl/ahb_apb_bridge_param_if.sv | 38 +++
 rtl/ahb_apb_decode.sv | 20 ++
 rtl/ahb_apb_bridge_param.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB codes, bridge state encoding and sizing helpers.
// Imported by the decoder and the bridge top.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Width of the slave index field: at least one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // NONSEQ and SEQ start a transfer; IDLE and BUSY do not.
    function automatic logic htrans_valid(input logic [1:0] t);
        case (t)
            HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_apb_bridge_param_if.sv
// AHB-side and APB-side bus signals of the bridge.
// slave = bridge view, master = environment (AHB master + APB slaves) view.
interface ahb_apb_bridge_param_if #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int NSLV = 3
);
    logic               hwrite;
    logic               hready_in;
    logic [1:0]         htrans;
    logic [AW-1:0]      haddr;
    logic [DW-1:0]      hwdata;
    logic [DW-1:0]      hrdata;
    logic               hreadyout;
    logic [1:0]         hresp;
    logic [NSLV-1:0]    psel;
    logic               penable;
    logic               pwrite;
    logic [AW-1:0]      paddr;
    logic [DW-1:0]      pwdata;
    logic [NSLV*DW-1:0] prdata;
    logic [NSLV-1:0]    pready;
    logic [NSLV-1:0]    pslverr;

    modport slave (
        input  hwrite, hready_in, htrans, haddr, hwdata,
        input  prdata, pready, pslverr,
        output hrdata, hreadyout, hresp,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport master (
        output hwrite, hready_in, htrans, haddr, hwdata,
        output prdata, pready, pslverr,
        input  hrdata, hreadyout, hresp,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/ahb_apb_decode.sv
// Slave decoder: haddr index field -> index, one-hot select, in_range.
// Ports: field (haddr[SEL_LSB +: SW]) in; idx, sel, in_range out.
module ahb_apb_decode
    import ahb_apb_pkg::*;
#(
    parameter int NSLV = 3,
    parameter int SW   = sel_width(NSLV)
) (
    input  logic [SW-1:0]   field,
    output logic [SW-1:0]   idx,
    output logic [NSLV-1:0] sel,
    output logic            in_range
);
    // One extra bit so NSLV = 2**SW still compares correctly.
    localparam logic [SW:0] LIMIT = (SW + 1)'(NSLV);

    assign idx      = field;
    assign in_range = ({1'b0, field} < LIMIT);
    assign sel      = in_range ? (NSLV'(1) << field) : '0;
endmodule

// File: rtl/ahb_apb_bridge_param.sv
// Parametrised AHB-Lite to APB bridge with wait states, slave errors,
// decode errors and optional timeout. Ports: hclk, hresetn, bus (slave).
module ahb_apb_bridge_param
    import ahb_apb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int NSLV    = 3,
    parameter int SEL_LSB = 28,
    parameter int TMO     = 16
) (
    input logic                   hclk,
    input logic                   hresetn,
    ahb_apb_bridge_param_if.slave bus
);
    localparam int SW = sel_width(NSLV);
    localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;

    state_t          state;
    logic [AW-1:0]   addr_q;
    logic            write_q;
    logic [SW-1:0]   idx_q;
    logic [NSLV-1:0] sel_q;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;

    logic [DW-1:0]   hrdata_r;
    logic            hreadyout_r;
    logic [1:0]      hresp_r;
    logic [NSLV-1:0] psel_r;
    logic            penable_r;
    logic            pwrite_r;
    logic [AW-1:0]   paddr_r;
    logic [DW-1:0]   pwdata_r;

    logic [SW-1:0]   dec_idx;
    logic [NSLV-1:0] dec_sel;
    logic            dec_in_range;

    logic            rdy;
    logic            slverr;
    logic [DW-1:0]   rdata;
    logic            accept;
    logic            tmo_hit;

    ahb_apb_decode #(.NSLV(NSLV), .SW(SW)) u_decode (
        .field    (bus.haddr[SEL_LSB +: SW]),
        .idx      (dec_idx),
        .sel      (dec_sel),
        .in_range (dec_in_range)
    );

    // Response mux for the latched slave.
    always_comb begin
        rdy    = 1'b0;
        slverr = 1'b0;
        rdata  = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (idx_q == SW'(i)) begin
                rdy    = bus.pready[i];
                slverr = bus.pslverr[i];
                rdata  = bus.prdata[i*DW +: DW];
            end
        end
    end

    // ERR2 drives hreadyout=1, so it can take a new transfer like IDLE.
    assign accept = (state == ST_IDLE || state == ST_ERR2)
                  && bus.hready_in && hreadyout_r
                  && htrans_valid(bus.htrans);

    assign cnt_nxt = cnt + 1'b1;
    assign tmo_hit = (TMO > 0) && (cnt_nxt == CW'(TMO));

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            idx_q       <= '0;
            sel_q       <= '0;
            cnt         <= '0;
            hrdata_r    <= '0;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
            psel_r      <= '0;
            penable_r   <= 1'b0;
            pwrite_r    <= 1'b0;
            paddr_r     <= '0;
            pwdata_r    <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_ERR2: begin
                    state   <= ST_IDLE;
                    hresp_r <= HRESP_OKAY;
                    if (accept) begin
                        addr_q      <= bus.haddr;
                        write_q     <= bus.hwrite;
                        idx_q       <= dec_idx;
                        sel_q       <= dec_sel;
                        hreadyout_r <= 1'b0;
                        if (dec_in_range) begin
                            state <= ST_WDATA;
                        end else begin
                            state   <= ST_ERR1;
                            hresp_r <= HRESP_ERROR;
                        end
                    end
                end
                ST_WDATA: begin
                    if (write_q) pwdata_r <= bus.hwdata;
                    psel_r   <= sel_q;
                    paddr_r  <= addr_q;
                    pwrite_r <= write_q;
                    cnt      <= '0;
                    state    <= ST_SETUP;
                end
                ST_SETUP: begin
                    penable_r <= 1'b1;
                    state     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready outranks both pslverr gating and expiry.
                    if (rdy) begin
                        psel_r    <= '0;
                        penable_r <= 1'b0;
                        if (slverr) begin
                            state   <= ST_ERR1;
                            hresp_r <= HRESP_ERROR;
                        end else begin
                            state       <= ST_IDLE;
                            hreadyout_r <= 1'b1;
                            if (!write_q) hrdata_r <= rdata;
                        end
                    end else begin
                        cnt <= cnt_nxt;
                        if (tmo_hit) begin
                            psel_r    <= '0;
                            penable_r <= 1'b0;
                            state     <= ST_ERR1;
                            hresp_r   <= HRESP_ERROR;
                        end
                    end
                end
                ST_ERR1: begin
                    hreadyout_r <= 1'b1;
                    state       <= ST_ERR2;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.hrdata    = hrdata_r;
    assign bus.hreadyout = hreadyout_r;
    assign bus.hresp     = hresp_r;
    assign bus.psel      = psel_r;
    assign bus.penable   = penable_r;
    assign bus.pwrite    = pwrite_r;
    assign bus.paddr     = paddr_r;
    assign bus.pwdata    = pwdata_r;
endmodule
